multi_sig_control: RTL and testbench
====================================

MULTI_SIG_CONTROL -- requirements
Module: multi_sig_control

Interface
REQ-001 SHALL have parameter N_ROADS, default 3, number of approach roads (legal 2..8); road 0 is the main road.
REQ-002 SHALL have parameter CW, default 8, width of all timing inputs and of the phase counter.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port car  input  N_ROADS  car[i]=1 when a vehicle waits on road i.
REQ-006 SHALL have port flash  input  1  maintenance flashing-mode request.
REQ-007 SHALL have port min_green, max_green, yel_time, ar_time  input  CW each  phase timings in cycles.
REQ-008 SHALL have port light  output  2*N_ROADS  light[2i+1:2i] is road i: RED=0, YELLOW=1, GREEN=2, OFF=3.
REQ-009 SHALL have port active  output  3  index of the road currently owning (or last owning) green.
REQ-010 SHALL have port phase  output  2  current state: GREEN=0, YELLOW=1, ALLRED=2, FLASH=3.

Function
REQ-011 SHALL be a Moore machine: states GREEN, YELLOW, ALLRED, FLASH; outputs decode combinationally from registered state, cur, cnt, flash toggle.
REQ-012 SHALL clear cnt to 0 on every state entry; otherwise increment each cycle, saturating at all-ones.
REQ-013 GREEN: road cur GREEN, all others RED; other_req = OR of car excluding car[cur].
REQ-014 GREEN -> YELLOW when other_req and (cnt >= max_green or (cnt >= min_green and car[cur]=0)); min_green > max_green means max_green governs.
REQ-015 SHALL latch nxt on the GREEN->YELLOW edge: first requester searching cur+1, cur+2, ... modulo N_ROADS.
REQ-016 GREEN with other_req=0 SHALL stay indefinitely (rest in green).
REQ-017 YELLOW: road cur YELLOW, others RED; lasts yel_time+1 cycles (exit on cnt==yel_time); -> ALLRED.
REQ-018 ALLRED: all RED; lasts ar_time+1 cycles; -> GREEN with cur=nxt.
REQ-019 flash=1 in any state SHALL force FLASH on the next edge (priority over all other transitions).
REQ-020 FLASH: all roads YELLOW then OFF, alternating every yel_time+1 cycles, starting YELLOW on entry.
REQ-021 flash=0 while in FLASH -> ALLRED with nxt=0; after ALLRED, road 0 GREEN.
REQ-022 Timing inputs SHALL be compared live each cycle; mid-phase changes take effect on the next comparison.
REQ-023 active SHALL equal cur; it changes only on ALLRED->GREEN or reset.

Reset
REQ-024 clear_n=0 at a rising edge SHALL set state GREEN, cur=0, nxt=0, cnt=0, flash toggle=YELLOW, regardless of current state.
REQ-025 During and after reset: light = road 0 GREEN, all others RED; active=0; phase=GREEN.

Structure
REQ-026 Shared package traffic_pkg SHALL hold light codes (RED/YELLOW/GREEN/OFF) and phase codes.
REQ-027 Next-requester search SHALL be sub-module rr_pick (inputs req, cur; output next index, valid), combinational.
REQ-028 No other sub-modules; single counter shared by all phases.

Verification (N_ROADS=3, CW=4, min_green=2, max_green=5, yel_time=1, ar_time=0, flash=0 unless stated)
REQ-029 clear_n=0 for 2 cycles -> light = {RED,RED,GREEN}, active=0, phase=GREEN.
REQ-030 car=3'b010 from reset -> road 0 GREEN 3 cycles, YELLOW 2, ALLRED 1, then road 1 GREEN, active=1.
REQ-031 car=3'b011 held -> road 0 GREEN 6 cycles (max_green cut-off), then YELLOW 2, ALLRED 1, road 1 GREEN.
REQ-032 road 1 GREEN, car=3'b101 -> after YELLOW/ALLRED, road 2 GREEN (round-robin), not road 0.
REQ-033 flash=1 during road 1 GREEN -> next edge phase=FLASH, all YELLOW 2 cycles, all OFF 2 cycles; flash=0 -> ALLRED 1 cycle, road 0 GREEN.
REQ-034 clear_n=0 one cycle mid-YELLOW on road 2 -> next edge road 0 GREEN, active=0, cnt=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light and phase encodings for the intersection controller.
package traffic_pkg;
  localparam logic [1:0] L_RED = 2'd0;
  localparam logic [1:0] L_YEL = 2'd1;
  localparam logic [1:0] L_GRN = 2'd2;
  localparam logic [1:0] L_OFF = 2'd3;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin next-requester search: first set req after cur, wrapping modulo N_ROADS.
module rr_pick #(
  parameter int N_ROADS = 3
) (
  input  logic [N_ROADS-1:0] req,
  input  logic [2:0]         cur,
  output logic [2:0]         nxt,
  output logic               valid
);
  logic [7:0] req8;
  logic [3:0] idx;

  assign req8 = 8'(req);

  // Walk farthest-to-nearest so the nearest requester after cur wins.
  always_comb begin
    nxt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_ROADS - 1; k >= 1; k--) begin
      idx = {1'b0, cur} + 4'(k);
      if (idx >= 4'(N_ROADS)) idx = idx - 4'(N_ROADS);
      if (req8[idx[2:0]]) begin
        nxt   = idx[2:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_sig_control.sv
// Multi-road traffic signal controller: round-robin green, yellow/all-red clearance, flash mode.
module multi_sig_control
  import traffic_pkg::*;
#(
  parameter int N_ROADS = 3,
  parameter int CW      = 8
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic [N_ROADS-1:0]     car,
  input  logic                   flash,
  input  logic [CW-1:0]          min_green,
  input  logic [CW-1:0]          max_green,
  input  logic [CW-1:0]          yel_time,
  input  logic [CW-1:0]          ar_time,
  output logic [2*N_ROADS-1:0]   light,
  output logic [2:0]             active,
  output logic [1:0]             phase
);
  phase_t        state, state_n;
  logic [2:0]    cur, cur_n, nxt, nxt_n, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic          ftog, ftog_n;   // 0: flash lamps lit yellow, 1: dark
  logic          other_req, flash_wrap;
  logic [7:0]    car8;

  assign car8 = 8'(car);

  rr_pick #(.N_ROADS(N_ROADS)) u_pick (
    .req   (car),
    .cur   (cur),
    .nxt   (pick),
    .valid (other_req)
  );

  assign flash_wrap = (state == PH_FLASH) && flash && (cnt == yel_time);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= PH_GREEN;
      cur   <= '0;
      nxt   <= '0;
      cnt   <= '0;
      ftog  <= 1'b0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      nxt   <= nxt_n;
      cnt   <= cnt_n;
      ftog  <= ftog_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    nxt_n   = nxt;
    ftog_n  = ftog;
    if (flash) begin
      if (state != PH_FLASH) begin
        state_n = PH_FLASH;
        ftog_n  = 1'b0;
      end else if (flash_wrap) begin
        ftog_n = ~ftog;
      end
    end else begin
      case (state)
        PH_GREEN:
          if (other_req && ((cnt >= max_green) || ((cnt >= min_green) && !car8[cur]))) begin
            state_n = PH_YELLOW;
            nxt_n   = pick;
          end
        PH_YELLOW: if (cnt == yel_time) state_n = PH_ALLRED;
        PH_ALLRED:
          if (cnt == ar_time) begin
            state_n = PH_GREEN;
            cur_n   = nxt;
          end
        default: begin
          state_n = PH_ALLRED;
          nxt_n   = '0;
        end
      endcase
    end
    // One counter serves every phase and also paces the flash blink.
    if (state_n != state || flash_wrap) cnt_n = '0;
    else if (cnt == '1)                 cnt_n = cnt;
    else                                cnt_n = cnt + CW'(1);
  end

  always_comb begin
    light = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      case (state)
        PH_GREEN:  light[2*i +: 2] = (3'(i) == cur) ? L_GRN : L_RED;
        PH_YELLOW: light[2*i +: 2] = (3'(i) == cur) ? L_YEL : L_RED;
        PH_ALLRED: light[2*i +: 2] = L_RED;
        default:   light[2*i +: 2] = ftog ? L_OFF : L_YEL;
      endcase
    end
  end

  assign active = cur;
  assign phase  = state;
endmodule

// File: tb/tb_multi_sig_control.sv
// Directed checks of the signal controller with hand-computed light/phase sequences.
module tb_multi_sig_control;
  logic       clock = 1'b0;
  logic       clear_n;
  logic [2:0] car;
  logic       flash;
  logic [3:0] min_green, max_green, yel_time, ar_time;
  logic [5:0] light;
  logic [2:0] active;
  logic [1:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] G0 = 6'b00_00_10, Y0 = 6'b00_00_01;
  localparam logic [5:0] G1 = 6'b00_10_00, Y1 = 6'b00_01_00;
  localparam logic [5:0] G2 = 6'b10_00_00, Y2 = 6'b01_00_00;
  localparam logic [5:0] AR = 6'b00_00_00, FY = 6'b01_01_01, FO = 6'b11_11_11;
  localparam logic [1:0] P_G = 2'd0, P_Y = 2'd1, P_A = 2'd2, P_F = 2'd3;

  multi_sig_control #(.N_ROADS(3), .CW(4)) dut (
    .clock(clock), .clear_n(clear_n), .car(car), .flash(flash),
    .min_green(min_green), .max_green(max_green), .yel_time(yel_time), .ar_time(ar_time),
    .light(light), .active(active), .phase(phase)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] l, input logic [2:0] a, input logic [1:0] p);
    n_cmp++;
    assert (light === l) else begin
      n_bad++;
      $error("FAIL %s light got=%b want=%b", tag, light, l);
    end
    n_cmp++;
    assert (active === a) else begin
      n_bad++;
      $error("FAIL %s active got=%0d want=%0d", tag, active, a);
    end
    n_cmp++;
    assert (phase === p) else begin
      n_bad++;
      $error("FAIL %s phase got=%0d want=%0d", tag, phase, p);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] l, input logic [2:0] a, input logic [1:0] p);
    chk(tag, l, a, p);
    tick();
  endtask

  initial begin
    clear_n = 1'b0; car = 3'b000; flash = 1'b0;
    min_green = 4'd2; max_green = 4'd5; yel_time = 4'd1; ar_time = 4'd0;
    tick(); tick();
    chk("reset", G0, 3'd0, P_G);

    // Gap-out: road 0 idle, road 1 waiting.
    clear_n = 1'b1; car = 3'b010;
    step("gap_g0a", G0, 3'd0, P_G);
    step("gap_g0b", G0, 3'd0, P_G);
    step("gap_g0c", G0, 3'd0, P_G);
    step("gap_y0a", Y0, 3'd0, P_Y);
    step("gap_y0b", Y0, 3'd0, P_Y);
    step("gap_ar",  AR, 3'd0, P_A);
    chk("gap_g1", G1, 3'd1, P_G);

    // Round-robin from road 1 must pick road 2 before road 0.
    car = 3'b101;
    step("rr_g1a", G1, 3'd1, P_G);
    step("rr_g1b", G1, 3'd1, P_G);
    step("rr_g1c", G1, 3'd1, P_G);
    step("rr_y1a", Y1, 3'd1, P_Y);
    step("rr_y1b", Y1, 3'd1, P_Y);
    step("rr_ar",  AR, 3'd1, P_A);
    chk("rr_g2", G2, 3'd2, P_G);

    // Reset asserted for one edge in the middle of road 2 yellow.
    car = 3'b001;
    step("mr_g2a", G2, 3'd2, P_G);
    step("mr_g2b", G2, 3'd2, P_G);
    step("mr_g2c", G2, 3'd2, P_G);
    step("mr_y2",  Y2, 3'd2, P_Y);
    clear_n = 1'b0;
    tick();
    chk("mr_rst", G0, 3'd0, P_G);

    // Max-green cut-off with road 0 still occupied; also proves cnt restarted at 0.
    clear_n = 1'b1; car = 3'b011;
    for (int i = 0; i < 6; i++) step($sformatf("max_g0_%0d", i), G0, 3'd0, P_G);
    step("max_y0a", Y0, 3'd0, P_Y);
    step("max_y0b", Y0, 3'd0, P_Y);
    step("max_ar",  AR, 3'd0, P_A);
    chk("max_g1", G1, 3'd1, P_G);

    // Flash mode from road 1 green, then back through all-red to road 0.
    flash = 1'b1;
    tick();
    step("fl_ya", FY, 3'd1, P_F);
    step("fl_yb", FY, 3'd1, P_F);
    step("fl_oa", FO, 3'd1, P_F);
    chk("fl_ob", FO, 3'd1, P_F);
    flash = 1'b0;
    tick();
    chk("fl_ar", AR, 3'd1, P_A);
    tick();
    chk("fl_g0", G0, 3'd0, P_G);

    // No competing request: rest in green.
    car = 3'b001;
    for (int i = 0; i < 8; i++) step($sformatf("rest_%0d", i), G0, 3'd0, P_G);
    car = 3'b000;
    tick();
    chk("rest_idle", G0, 3'd0, P_G);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
